// File: rtl/irq_nest_ctrl.sv
// Nesting interrupt controller: N prioritised channels, hardware EPC stack, pipeline flush/PC force.
// Latency: irq_in rise -> pending at 3rd clock edge; take/eret decision -> force/flush the following cycle.
// No backpressure: requests stay latched in pending until taken; stack-full or lower-priority requests wait.
module irq_nest_ctrl #(
  parameter int unsigned N_IRQ      = 3,
  parameter int unsigned DEPTH      = 3,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0040
) (
  input  logic             in_CLK,
  input  logic             in_RST,
  input  logic [N_IRQ-1:0] irq_in_i,
  input  logic             ie_i,
  input  logic [N_IRQ-1:0] mask_i,
  input  logic             take_ok_i,
  input  logic [31:0]      wb_pc_i,
  input  logic             eret_i,
  output logic             force_o,
  output logic [31:0]      force_addr_o,
  output logic             flush_o,
  output logic [31:0]      epc_o,
  output logic [3:0]       level_o,
  output logic [N_IRQ-1:0] pending_o,
  output logic [3:0]       depth_o,
  output logic             err_underflow_o
);

  logic [N_IRQ-1:0] sync1_q, sync2_q, prev_q;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [3:0]       level_q, level_d;
  logic [3:0]       depth_q, depth_d;
  logic             force_q, force_d;
  logic [31:0]      force_addr_q, force_addr_d;
  logic             underflow_q;
  logic [31:0]      stk_pc_q  [DEPTH];
  logic [3:0]       stk_lvl_q [DEPTH];

  logic [N_IRQ-1:0] rise, elig, clr;
  logic [3:0]       cand, cand_lvl;
  logic [31:0]      top_pc;
  logic [3:0]       top_lvl;
  logic             take, pop, uflow;

  assign rise = sync2_q & ~prev_q;
  assign elig = pending_q & mask_i;

  // Highest-index eligible channel wins arbitration
  always_comb begin
    cand = 4'd0;
    for (int k = 0; k < N_IRQ; k++) begin
      if (elig[k]) cand = 4'(k);
    end
  end

  assign cand_lvl = cand + 4'd1;

  // eret and any pending force both block a take; a forced cycle also drops eret
  assign take  = ie_i & take_ok_i & (|elig) & (cand_lvl > level_q) &
                 (depth_q < 4'(DEPTH)) & ~eret_i & ~force_q;
  assign pop   = eret_i & (depth_q != 4'd0) & ~force_q;
  assign uflow = eret_i & (depth_q == 4'd0) & ~force_q;

  // Read the top-of-stack entry (zero when the stack is empty)
  always_comb begin
    top_pc  = 32'd0;
    top_lvl = 4'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (depth_q == 4'(i + 1)) begin
        top_pc  = stk_pc_q[i];
        top_lvl = stk_lvl_q[i];
      end
    end
  end

  // Clear only the taken channel; a new edge on the same cycle re-sets it
  always_comb begin
    clr = '0;
    for (int k = 0; k < N_IRQ; k++) begin
      clr[k] = take && (cand == 4'(k));
    end
    pending_d = (pending_q & ~clr) | rise;
  end

  // Next service level, stack occupancy and force pulse
  always_comb begin
    level_d      = level_q;
    depth_d      = depth_q;
    force_d      = 1'b0;
    force_addr_d = force_addr_q;
    if (pop) begin
      level_d      = top_lvl;
      depth_d      = depth_q - 4'd1;
      force_d      = 1'b1;
      force_addr_d = top_pc;
    end else if (take) begin
      level_d      = cand_lvl;
      depth_d      = depth_q + 4'd1;
      force_d      = 1'b1;
      force_addr_d = VEC_BASE + ({28'd0, cand} * VEC_STRIDE);
    end
  end

  // Synchronisers, edge detector and control state
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      pending_q    <= '0;
      level_q      <= 4'd0;
      depth_q      <= 4'd0;
      force_q      <= 1'b0;
      force_addr_q <= 32'd0;
      underflow_q  <= 1'b0;
    end else begin
      sync1_q      <= irq_in_i;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      pending_q    <= pending_d;
      level_q      <= level_d;
      depth_q      <= depth_d;
      force_q      <= force_d;
      force_addr_q <= force_addr_d;
      if (uflow) underflow_q <= 1'b1;
    end
  end

  // EPC stack: push writes the slot at the current occupancy
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        stk_pc_q[i]  <= 32'd0;
        stk_lvl_q[i] <= 4'd0;
      end
    end else if (take) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (depth_q == 4'(i)) begin
          stk_pc_q[i]  <= wb_pc_i;
          stk_lvl_q[i] <= level_q;
        end
      end
    end
  end

  assign force_o         = force_q;
  assign flush_o         = force_q;
  assign force_addr_o    = force_addr_q;
  assign epc_o           = top_pc;
  assign level_o         = level_q;
  assign pending_o       = pending_q;
  assign depth_o         = depth_q;
  assign err_underflow_o = underflow_q;

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Bench for irq_nest_ctrl: table of per-cycle vectors on a DEPTH=3 instance,
// plus hand-written sequences on a DEPTH=1 instance (stack full, underflow, reset during force).
module tb_irq_nest_ctrl;

  logic        in_CLK = 1'b0;
  logic        in_RST;
  logic [2:0]  irq_in;
  logic        ie, take_ok, eret;
  logic [2:0]  mask;
  logic [31:0] wb_pc;

  logic        frc, flush, uf;
  logic [31:0] faddr, epc;
  logic [3:0]  level, depth;
  logic [2:0]  pend;

  logic        d1_frc, d1_flush, d1_uf;
  logic [31:0] d1_faddr, d1_epc;
  logic [3:0]  d1_level, d1_depth;
  logic [2:0]  d1_pend;

  int checks = 0;
  int errors = 0;

  always #5 in_CLK = ~in_CLK;

  irq_nest_ctrl #(.N_IRQ(3), .DEPTH(3)) dut (
    .in_CLK(in_CLK), .in_RST(in_RST), .irq_in_i(irq_in), .ie_i(ie), .mask_i(mask),
    .take_ok_i(take_ok), .wb_pc_i(wb_pc), .eret_i(eret),
    .force_o(frc), .force_addr_o(faddr), .flush_o(flush), .epc_o(epc),
    .level_o(level), .pending_o(pend), .depth_o(depth), .err_underflow_o(uf)
  );

  irq_nest_ctrl #(.N_IRQ(3), .DEPTH(1)) dut1 (
    .in_CLK(in_CLK), .in_RST(in_RST), .irq_in_i(irq_in), .ie_i(ie), .mask_i(mask),
    .take_ok_i(take_ok), .wb_pc_i(wb_pc), .eret_i(eret),
    .force_o(d1_frc), .force_addr_o(d1_faddr), .flush_o(d1_flush), .epc_o(d1_epc),
    .level_o(d1_level), .pending_o(d1_pend), .depth_o(d1_depth), .err_underflow_o(d1_uf)
  );

  typedef struct {
    logic [2:0]  irq;
    logic        eret;
    logic [31:0] pc;
    logic        frc;
    logic [31:0] addr;
    logic [3:0]  lvl;
    logic [3:0]  dep;
    logic [31:0] epc;
    logic [2:0]  pend;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(input logic [2:0] irq_v, input logic eret_v, input logic [31:0] pc_v,
                              input logic frc_v, input logic [31:0] addr_v, input logic [3:0] lvl_v,
                              input logic [3:0] dep_v, input logic [31:0] epc_v, input logic [2:0] pend_v);
    vec_t v;
    v.irq = irq_v; v.eret = eret_v; v.pc = pc_v; v.frc = frc_v; v.addr = addr_v;
    v.lvl = lvl_v; v.dep = dep_v; v.epc = epc_v; v.pend = pend_v;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge in_CLK);
    #1;
  endtask

  initial begin
    // irq, eret, wb_pc | force, force_addr, level, depth, epc, pending
    tbl[0]  = mk(3'b010, 0, 32'h20,  0, 32'h0,   0, 0, 32'h0,   3'b000);
    tbl[1]  = mk(3'b000, 0, 32'h20,  0, 32'h0,   0, 0, 32'h0,   3'b000);
    tbl[2]  = mk(3'b000, 0, 32'h20,  0, 32'h0,   0, 0, 32'h0,   3'b010);
    tbl[3]  = mk(3'b000, 0, 32'h20,  1, 32'h140, 2, 1, 32'h20,  3'b000);
    tbl[4]  = mk(3'b100, 0, 32'h150, 0, 32'h140, 2, 1, 32'h20,  3'b000);
    tbl[5]  = mk(3'b000, 0, 32'h150, 0, 32'h140, 2, 1, 32'h20,  3'b000);
    tbl[6]  = mk(3'b000, 0, 32'h150, 0, 32'h140, 2, 1, 32'h20,  3'b100);
    tbl[7]  = mk(3'b000, 0, 32'h150, 1, 32'h180, 3, 2, 32'h150, 3'b000);
    tbl[8]  = mk(3'b001, 0, 32'h150, 0, 32'h180, 3, 2, 32'h150, 3'b000);
    tbl[9]  = mk(3'b000, 0, 32'h150, 0, 32'h180, 3, 2, 32'h150, 3'b000);
    tbl[10] = mk(3'b000, 0, 32'h150, 0, 32'h180, 3, 2, 32'h150, 3'b001);
    tbl[11] = mk(3'b000, 0, 32'h150, 0, 32'h180, 3, 2, 32'h150, 3'b001);
    tbl[12] = mk(3'b000, 1, 32'h150, 1, 32'h150, 2, 1, 32'h20,  3'b001);
    tbl[13] = mk(3'b000, 0, 32'h150, 0, 32'h150, 2, 1, 32'h20,  3'b001);
    tbl[14] = mk(3'b000, 1, 32'h150, 1, 32'h20,  0, 0, 32'h0,   3'b001);
    tbl[15] = mk(3'b000, 0, 32'h60,  0, 32'h20,  0, 0, 32'h0,   3'b001);
    tbl[16] = mk(3'b000, 0, 32'h60,  1, 32'h100, 1, 1, 32'h60,  3'b000);
    tbl[17] = mk(3'b010, 0, 32'h70,  0, 32'h100, 1, 1, 32'h60,  3'b000);
    tbl[18] = mk(3'b000, 0, 32'h70,  0, 32'h100, 1, 1, 32'h60,  3'b000);
    tbl[19] = mk(3'b000, 0, 32'h70,  0, 32'h100, 1, 1, 32'h60,  3'b010);
    tbl[20] = mk(3'b000, 1, 32'h70,  1, 32'h60,  0, 0, 32'h0,   3'b010);
    tbl[21] = mk(3'b000, 0, 32'h70,  0, 32'h60,  0, 0, 32'h0,   3'b010);
    tbl[22] = mk(3'b000, 0, 32'h70,  1, 32'h140, 2, 1, 32'h70,  3'b000);
    tbl[23] = mk(3'b000, 0, 32'h70,  0, 32'h140, 2, 1, 32'h70,  3'b000);

    in_RST = 1'b1; irq_in = 3'b000; ie = 1'b1; mask = 3'b111; take_ok = 1'b1;
    wb_pc = 32'h20; eret = 1'b0;
    #2;
    chk("rst_force", {31'd0, frc}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_addr", faddr, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_level", {28'd0, level}, 32'd0);
    chk("rst_depth", {28'd0, depth}, 32'd0);
    chk("rst_pending", {29'd0, pend}, 32'd0);
    chk("rst_uflow", {31'd0, uf}, 32'd0);
    #10;
    in_RST = 1'b0;

    for (int r = 0; r < 24; r++) begin
      irq_in = tbl[r].irq;
      eret   = tbl[r].eret;
      wb_pc  = tbl[r].pc;
      step();
      chk($sformatf("row%0d_force", r), {31'd0, frc}, {31'd0, tbl[r].frc});
      chk($sformatf("row%0d_flush", r), {31'd0, flush}, {31'd0, tbl[r].frc});
      chk($sformatf("row%0d_addr", r), faddr, tbl[r].addr);
      chk($sformatf("row%0d_level", r), {28'd0, level}, {28'd0, tbl[r].lvl});
      chk($sformatf("row%0d_depth", r), {28'd0, depth}, {28'd0, tbl[r].dep});
      chk($sformatf("row%0d_epc", r), epc, tbl[r].epc);
      chk($sformatf("row%0d_pending", r), {29'd0, pend}, {29'd0, tbl[r].pend});
    end
    chk("tbl_uflow", {31'd0, uf}, 32'd0);

    // DEPTH=1: second request held while stack full, then underflow
    irq_in = 3'b000; eret = 1'b0; wb_pc = 32'h10;
    in_RST = 1'b1; #2; in_RST = 1'b0;
    irq_in = 3'b001; step(); irq_in = 3'b000; step(); step();
    chk("d1_pend0", {29'd0, d1_pend}, 32'b001);
    step();
    chk("d1_take0_force", {31'd0, d1_frc}, 32'd1);
    chk("d1_take0_addr", d1_faddr, 32'h100);
    chk("d1_take0_level", {28'd0, d1_level}, 32'd1);
    chk("d1_take0_depth", {28'd0, d1_depth}, 32'd1);
    chk("d1_take0_epc", d1_epc, 32'h10);
    irq_in = 3'b010; step(); irq_in = 3'b000; step(); step();
    chk("d1_pend1", {29'd0, d1_pend}, 32'b010);
    step();
    chk("d1_full_force", {31'd0, d1_frc}, 32'd0);
    chk("d1_full_pend", {29'd0, d1_pend}, 32'b010);
    chk("d1_full_level", {28'd0, d1_level}, 32'd1);
    wb_pc = 32'h30;
    eret = 1'b1; step(); eret = 1'b0;
    chk("d1_ret_force", {31'd0, d1_frc}, 32'd1);
    chk("d1_ret_addr", d1_faddr, 32'h10);
    chk("d1_ret_level", {28'd0, d1_level}, 32'd0);
    chk("d1_ret_depth", {28'd0, d1_depth}, 32'd0);
    step();
    chk("d1_blocked_force", {31'd0, d1_frc}, 32'd0);
    chk("d1_blocked_pend", {29'd0, d1_pend}, 32'b010);
    step();
    chk("d1_take1_force", {31'd0, d1_frc}, 32'd1);
    chk("d1_take1_addr", d1_faddr, 32'h140);
    chk("d1_take1_level", {28'd0, d1_level}, 32'd2);
    chk("d1_take1_epc", d1_epc, 32'h30);
    step();
    eret = 1'b1; step(); eret = 1'b0;
    chk("d1_ret2_addr", d1_faddr, 32'h30);
    chk("d1_ret2_depth", {28'd0, d1_depth}, 32'd0);
    step();
    eret = 1'b1; step(); eret = 1'b0;
    chk("d1_uflow", {31'd0, d1_uf}, 32'd1);
    chk("d1_uflow_force", {31'd0, d1_frc}, 32'd0);
    chk("d1_uflow_depth", {28'd0, d1_depth}, 32'd0);

    // Reset asserted while force is high
    irq_in = 3'b101; step(); irq_in = 3'b000; step(); step(); step();
    chk("d1_pre_rst_force", {31'd0, d1_frc}, 32'd1);
    chk("d1_pre_rst_addr", d1_faddr, 32'h180);
    chk("d1_pre_rst_pend", {29'd0, d1_pend}, 32'b001);
    in_RST = 1'b1;
    #1;
    chk("mrst_force", {31'd0, d1_frc}, 32'd0);
    chk("mrst_flush", {31'd0, d1_flush}, 32'd0);
    chk("mrst_addr", d1_faddr, 32'd0);
    chk("mrst_level", {28'd0, d1_level}, 32'd0);
    chk("mrst_depth", {28'd0, d1_depth}, 32'd0);
    chk("mrst_epc", d1_epc, 32'd0);
    chk("mrst_pend", {29'd0, d1_pend}, 32'd0);
    chk("mrst_uflow", {31'd0, d1_uf}, 32'd0);
    #3;
    in_RST = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
